// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and the fetch-address legality check
// for the F stage.
package fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER  = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI  = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fstate_e;

  function automatic logic pc_bad(
    input logic [31:0] pc,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between F stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_npc.sv
// Next-PC priority mux: exception, ERET, taken branch, then sequential.
module fetch_npc
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER = DEF_HANDLER
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] target_i,
  input  logic [31:0] tgt_pend_i,
  input  logic        req_i,
  input  logic        kill_i,
  input  logic        adv_i,
  input  logic        redirect_i,
  input  logic        redir_pend_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_i;
    priority case (1'b1)
      req_i:                   npc_o = HANDLER;
      kill_i:                  npc_o = epc_i;
      adv_i && redir_pend_i:   npc_o = tgt_pend_i;
      adv_i && redirect_i:     npc_o = target_i;
      adv_i:                   npc_o = pc_i + 32'd4;
      default:                 npc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// F stage: owns the PC, runs the imem handshake and feeds the D register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] HANDLER  = DEF_HANDLER,
  parameter logic [31:0] TEXT_LO  = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI  = DEF_TEXT_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        Req,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic        ctrl_D,
  input  logic        redirect_D,
  input  logic [31:0] target_D,
  fetch_unit_if.master imem,
  output logic        valid_F,
  output logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic        BD_F,
  output logic [4:0]  ExcCode_F
);

  fstate_e     st_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] buf_q;
  logic [31:0] daddr_q;
  logic [31:0] tgt_q;
  logic        bd_pend_q;
  logic        redir_pend_q;

  logic issue;
  logic hold;
  logic drain;
  logic bad;
  logic kill;
  logic flush;
  logic adv;

  assign issue = (st_q == ST_ISSUE);
  assign hold  = (st_q == ST_HOLD);
  assign drain = (st_q == ST_DRAIN);
  assign bad   = issue && pc_bad(pc_q, TEXT_LO, TEXT_HI);
  assign kill  = eret_D && !stall_D;
  assign flush = Req || kill;

  // A drained request keeps presenting the address it was issued with
  assign imem.imem_req  = reset && (drain || (issue && !bad));
  assign imem.imem_addr = drain ? daddr_q : pc_q;

  assign valid_F = reset && !kill &&
                   ((issue && (bad || imem.imem_ready)) || hold);
  assign adv     = valid_F && !stall_D;

  assign instr_F   = (valid_F && !bad)
                   ? (hold ? buf_q : imem.imem_rdata) : '0;
  assign ExcCode_F = (valid_F && bad) ? EXC_ADEL : EXC_NONE;
  assign PC_F      = pc_q;
  assign BD_F      = reset && (ctrl_D || bd_pend_q);

  fetch_npc #(
    .HANDLER (HANDLER)
  ) u_npc (
    .pc_i         (pc_q),
    .epc_i        (EPC),
    .target_i     (target_D),
    .tgt_pend_i   (tgt_q),
    .req_i        (Req),
    .kill_i       (kill),
    .adv_i        (adv),
    .redirect_i   (redirect_D),
    .redir_pend_i (redir_pend_q),
    .npc_o        (pc_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= ST_ISSUE;
      pc_q         <= RESET_PC;
      buf_q        <= '0;
      daddr_q      <= '0;
      tgt_q        <= '0;
      bd_pend_q    <= 1'b0;
      redir_pend_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (flush) begin
        bd_pend_q    <= 1'b0;
        redir_pend_q <= 1'b0;
        if (imem.imem_req && !imem.imem_ready) begin
          st_q <= ST_DRAIN;
          if (issue) daddr_q <= pc_q;
        end else begin
          st_q <= ST_ISSUE;
        end
      end else begin
        unique case (st_q)
          ST_ISSUE: begin
            if (!bad && imem.imem_ready && !adv) begin
              buf_q <= imem.imem_rdata;
              st_q  <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (adv) st_q <= ST_ISSUE;
          end
          ST_DRAIN: begin
            if (imem.imem_ready) st_q <= ST_ISSUE;
          end
          default: st_q <= ST_ISSUE;
        endcase
        // Branch left D before its delay slot was delivered
        if (adv) begin
          bd_pend_q    <= 1'b0;
          redir_pend_q <= 1'b0;
        end else if (ctrl_D && !stall_D) begin
          bd_pend_q <= 1'b1;
          if (redirect_D) begin
            redir_pend_q <= 1'b1;
            tgt_q        <= target_D;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus randomized run against a flag-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_D;
  logic        Req;
  logic        eret_D;
  logic [31:0] EPC;
  logic        ctrl_D;
  logic        redirect_D;
  logic [31:0] target_D;
  logic        rdy;
  logic [31:0] junk;
  logic        valid_F;
  logic [31:0] instr_F;
  logic [31:0] PC_F;
  logic        BD_F;
  logic [4:0]  ExcCode_F;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  fetch_unit_if bus();
  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = rdy ? memf(bus.imem_addr) : junk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall_D    (stall_D),
    .Req        (Req),
    .eret_D     (eret_D),
    .EPC        (EPC),
    .ctrl_D     (ctrl_D),
    .redirect_D (redirect_D),
    .target_D   (target_D),
    .imem       (bus.master),
    .valid_F    (valid_F),
    .instr_F    (instr_F),
    .PC_F       (PC_F),
    .BD_F       (BD_F),
    .ExcCode_F  (ExcCode_F)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall_D = 0; Req = 0; eret_D = 0; ctrl_D = 0; redirect_D = 0;
    EPC = 0; target_D = 0; rdy = 1; junk = 32'hDEAD_BEEF;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if ({bus.imem_req, valid_F, BD_F} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got req/valid/bd=%b exp=000",
               {bus.imem_req, valid_F, BD_F});
    end
    checks++;
    if (instr_F !== 32'h0 || PC_F !== 32'h3000 || ExcCode_F !== 5'd0) begin
      failures++;
      $display("FAIL reset_data got instr=%h pc=%h exc=%0d exp 0/3000/0",
               instr_F, PC_F, ExcCode_F);
    end
  endtask

  task automatic test_seq();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h3000 + 32'(4 * i);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin
        failures++;
        $display("FAIL seq_addr got req=%b addr=%h exp 1/%h",
                 bus.imem_req, bus.imem_addr, a);
      end
      checks++;
      if (valid_F !== 1'b1 || instr_F !== memf(a)) begin
        failures++;
        $display("FAIL seq_data got v=%b instr=%h exp 1/%h",
                 valid_F, instr_F, memf(a));
      end
      cyc();
    end
  endtask

  task automatic test_wait();
    do_reset();
    cyc();
    rdy = 0;
    junk = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
        failures++;
        $display("FAIL wait_addr got req=%b addr=%h exp 1/3004",
                 bus.imem_req, bus.imem_addr);
      end
      checks++;
      if (valid_F !== 1'b0 || instr_F !== 32'h0) begin
        failures++;
        $display("FAIL wait_bubble got v=%b instr=%h exp 0/0",
                 valid_F, instr_F);
      end
      cyc();
    end
    rdy = 1;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b1 || instr_F !== memf(32'h3004)) begin
      failures++;
      $display("FAIL wait_deliver got v=%b instr=%h exp 1/%h",
               valid_F, instr_F, memf(32'h3004));
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 32'h3008) begin
      failures++;
      $display("FAIL wait_next got addr=%h exp 3008", bus.imem_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall_D = 1;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b1 || instr_F !== memf(32'h3000)) begin
      failures++;
      $display("FAIL stall_first got v=%b instr=%h exp 1/%h",
               valid_F, instr_F, memf(32'h3000));
    end
    cyc();
    rdy = 0;
    junk = $urandom;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || valid_F !== 1'b1 ||
        instr_F !== memf(32'h3000) || PC_F !== 32'h3000) begin
      failures++;
      $display("FAIL stall_hold got req=%b v=%b instr=%h pc=%h exp 0/1/%h/3000",
               bus.imem_req, valid_F, instr_F, PC_F, memf(32'h3000));
    end
    cyc();
    stall_D = 0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || valid_F !== 1'b1 ||
        instr_F !== memf(32'h3000)) begin
      failures++;
      $display("FAIL stall_release got req=%b v=%b instr=%h exp 0/1/%h",
               bus.imem_req, valid_F, instr_F, memf(32'h3000));
    end
    cyc();
    rdy = 1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
      failures++;
      $display("FAIL stall_next got req=%b addr=%h exp 1/3004",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    cyc();
    rdy = 0;
    ctrl_D = 1; redirect_D = 1; target_D = 32'h3100;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b0 || BD_F !== 1'b1) begin
      failures++;
      $display("FAIL br_leave got v=%b bd=%b exp 0/1", valid_F, BD_F);
    end
    cyc();
    ctrl_D = 0; redirect_D = 0; target_D = 32'h5555_0000;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b0 || BD_F !== 1'b1) begin
      failures++;
      $display("FAIL br_pend got v=%b bd=%b exp 0/1", valid_F, BD_F);
    end
    cyc();
    rdy = 1;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b1 || BD_F !== 1'b1 || PC_F !== 32'h3004 ||
        instr_F !== memf(32'h3004)) begin
      failures++;
      $display("FAIL br_slot got v=%b bd=%b pc=%h instr=%h exp 1/1/3004/%h",
               valid_F, BD_F, PC_F, instr_F, memf(32'h3004));
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 32'h3100 || BD_F !== 1'b0) begin
      failures++;
      $display("FAIL br_target got addr=%h bd=%b exp 3100/0",
               bus.imem_addr, BD_F);
    end
  endtask

  task automatic test_req();
    do_reset();
    repeat (4) cyc();
    rdy = 0;
    ctrl_D = 1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3010) begin
      failures++;
      $display("FAIL req_pre got req=%b addr=%h exp 1/3010",
               bus.imem_req, bus.imem_addr);
    end
    cyc();
    ctrl_D = 0;
    Req = 1;
    cyc();
    Req = 0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3010 ||
        valid_F !== 1'b0) begin
      failures++;
      $display("FAIL req_drain got req=%b addr=%h v=%b exp 1/3010/0",
               bus.imem_req, bus.imem_addr, valid_F);
    end
    cyc();
    rdy = 1;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b0 || instr_F !== 32'h0) begin
      failures++;
      $display("FAIL req_discard got v=%b instr=%h exp 0/0", valid_F, instr_F);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 32'h4180 || valid_F !== 1'b1 || BD_F !== 1'b0) begin
      failures++;
      $display("FAIL req_handler got addr=%h v=%b bd=%b exp 4180/1/0",
               bus.imem_addr, valid_F, BD_F);
    end
  endtask

  task automatic test_adel();
    logic [31:0] bad_pc [2];
    bad_pc[0] = 32'h2FFC;
    bad_pc[1] = 32'h3002;
    do_reset();
    ctrl_D = 1; redirect_D = 1; target_D = bad_pc[0];
    cyc();
    for (int i = 0; i < 2; i++) begin
      target_D = bad_pc[1];
      if (i == 1) begin
        ctrl_D = 0; redirect_D = 0;
      end
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0 || valid_F !== 1'b1 || instr_F !== 32'h0 ||
          ExcCode_F !== 5'd4 || PC_F !== bad_pc[i]) begin
        failures++;
        $display("FAIL adel got req=%b v=%b instr=%h exc=%0d pc=%h exp 0/1/0/4/%h",
                 bus.imem_req, valid_F, instr_F, ExcCode_F, PC_F, bad_pc[i]);
      end
      cyc();
    end
  endtask

  task automatic test_eret();
    do_reset();
    eret_D = 1;
    EPC = 32'h3040;
    @(negedge clk);
    checks++;
    if (valid_F !== 1'b0 || instr_F !== 32'h0) begin
      failures++;
      $display("FAIL eret_kill got v=%b instr=%h exp 0/0", valid_F, instr_F);
    end
    cyc();
    eret_D = 0;
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 32'h3040 || valid_F !== 1'b1) begin
      failures++;
      $display("FAIL eret_next got addr=%h v=%b exp 3040/1",
               bus.imem_addr, valid_F);
    end
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(15);
    case (r)
      0:       return 32'h3001 + 32'($urandom_range(63) * 4);
      1:       return 32'h7000 + 32'($urandom_range(63) * 4);
      2:       return 32'h2FF0;
      3:       return 32'h6FFC;
      4:       return 32'h3000;
      default: return 32'h3000 + 32'($urandom_range(4095) * 4);
    endcase
  endfunction

  // Model: PC, whether its word is already captured, and a stale request
  task automatic test_random();
    logic [31:0] m_pc, m_sa, m_tgt;
    logic        m_got, m_stale, m_bd, m_rp;
    logic        bad, kill, e_req, e_valid, e_bd, adv;
    logic [31:0] e_instr;
    logic [4:0]  e_exc;
    do_reset();
    m_pc = 32'h3000; m_sa = 0; m_tgt = 0;
    m_got = 0; m_stale = 0; m_bd = 0; m_rp = 0;
    for (int n = 0; n < 3000; n++) begin
      stall_D    = ($urandom_range(9) < 3);
      rdy        = ($urandom_range(9) < 6);
      Req        = ($urandom_range(39) == 0);
      eret_D     = ($urandom_range(24) == 0);
      ctrl_D     = ($urandom_range(6) == 0);
      redirect_D = ctrl_D && $urandom_range(1) == 1;
      target_D   = rand_target();
      EPC        = rand_target();
      junk       = $urandom;
      @(negedge clk);
      bad     = (m_pc[1:0] != 0) || m_pc < 32'h3000 || m_pc > 32'h6FFC;
      kill    = eret_D && !stall_D;
      e_req   = m_stale || (!m_got && !bad);
      e_valid = !m_stale && (bad || m_got || rdy) && !kill;
      e_instr = (e_valid && !bad) ? memf(m_pc) : 32'h0;
      e_exc   = (e_valid && bad) ? 5'd4 : 5'd0;
      e_bd    = ctrl_D || m_bd;
      checks++;
      if (bus.imem_req !== e_req ||
          (e_req && bus.imem_addr !== (m_stale ? m_sa : m_pc))) begin
        failures++;
        $display("FAIL rnd_req n=%0d got req=%b addr=%h exp %b/%h", n,
                 bus.imem_req, bus.imem_addr, e_req, m_stale ? m_sa : m_pc);
      end
      checks++;
      if (valid_F !== e_valid || instr_F !== e_instr) begin
        failures++;
        $display("FAIL rnd_data n=%0d got v=%b instr=%h exp %b/%h", n,
                 valid_F, instr_F, e_valid, e_instr);
      end
      checks++;
      if (ExcCode_F !== e_exc || BD_F !== e_bd || PC_F !== m_pc) begin
        failures++;
        $display("FAIL rnd_meta n=%0d got exc=%0d bd=%b pc=%h exp %0d/%b/%h",
                 n, ExcCode_F, BD_F, PC_F, e_exc, e_bd, m_pc);
      end
      adv = e_valid && !stall_D;
      if (Req || kill) begin
        if (!m_stale) m_sa = m_pc;
        m_stale = e_req && !rdy;
        m_pc    = Req ? 32'h4180 : EPC;
        m_got = 0; m_bd = 0; m_rp = 0;
      end else begin
        if (m_stale) begin
          if (rdy) m_stale = 0;
        end else if (adv) begin
          m_pc  = m_rp ? m_tgt : (redirect_D ? target_D : m_pc + 32'd4);
          m_got = 0;
        end else if (!bad && rdy) begin
          m_got = 1;
        end
        if (adv) begin
          m_bd = 0; m_rp = 0;
        end else if (ctrl_D && !stall_D) begin
          m_bd = 1;
          if (redirect_D) begin
            m_rp = 1; m_tgt = target_D;
          end
        end
      end
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_seq();
    test_wait();
    test_stall();
    test_branch();
    test_req();
    test_adel();
    test_eret();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- F-stage producer for the D-stage pipeline register of the MIPS pipeline.
- Owns the PC register and the fetch handshake with a variable-latency instruction memory.
- Drives instr_F, PC_F, BD_F and ExcCode_F into the D register.
- Redirects fetch on branch/jump, exception request (Req) and ERET.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- HANDLER, 32'h0000_4180, exception entry PC
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall_D  in  1  hazard unit holds D; F must not advance
- Req  in  1  exception/interrupt taken this cycle
- eret_D  in  1  ERET in D
- EPC  in  32  return address from CP0
- ctrl_D  in  1  instr in D is branch/jump (next fetched instr is a delay slot)
- redirect_D  in  1  branch/jump in D is taken
- target_D  in  32  taken target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_ready  in  1  rdata valid; completes the request
- imem_rdata  in  32  instruction word
- valid_F  out  1  instr_F is a real fetch this cycle
- instr_F  out  32  instruction word, NOP (0) when !valid_F
- PC_F  out  32  PC of the F instruction
- BD_F  out  1  F instruction is a delay slot
- ExcCode_F  out  5  AdEL (4) or NONE (0)

Behaviour:
- Reset (reset=0), asynchronous:
  - PC=RESET_PC; FSM=ISSUE; buffer empty; bd_pend=0; redir_pend=0.
  - Outputs: imem_req=0, valid_F=0, instr_F=0, PC_F=RESET_PC, BD_F=0, ExcCode_F=0.
- FSM states:
  - ISSUE: imem_req=1, imem_addr=PC, both held stable until imem_ready.
    - imem_ready & adv → next PC, stay ISSUE.
    - imem_ready & !adv → latch rdata into buffer, go HOLD.
  - HOLD: imem_req=0; instr_F comes from the buffer; valid_F=1; on adv → ISSUE at next PC.
  - DRAIN: imem_req=1, old address held; response discarded; on imem_ready → ISSUE at current PC.
- valid_F = (ISSUE & imem_ready) | HOLD | AdEL, forced 0 when eret_D & !stall_D.
- Zero-latency ready: rdata passes combinationally to instr_F in the same cycle.
- adv = valid_F & !stall_D.
- AdEL: PC[1:0]≠0 or PC∉[TEXT_LO,TEXT_HI].
  - No imem_req; valid_F=1, instr_F=0, ExcCode_F=4.
  - PC advances normally on adv.
- Next-PC priority:
  1. Req → HANDLER, taken regardless of stall_D or FSM.
  2. eret_D & !stall_D → EPC; the current F instruction is killed (no delay slot).
  3. On adv, redirect_D | redir_pend → target (target_D, or the latched target when pending).
  4. On adv otherwise → PC+4, 32-bit wrap.
- Redirect/exception while a request is outstanding (ISSUE & !imem_ready): PC takes the new value and FSM goes to DRAIN.
- Redirect/exception from HOLD: buffer dropped, go to ISSUE.
- Req and eret both clear bd_pend and redir_pend.
- Pending branch (branch leaves D, i.e. !stall_D, before its delay slot is valid):
  - Set bd_pend.
  - Set redir_pend and latch target_D when redirect_D.
  - Both clear on the adv that delivers the delay slot.
- BD_F = ctrl_D | bd_pend.
- PC_F = PC.

Decomposition:
- Shared header gets:
  - RESET_PC, HANDLER, TEXT_LO, TEXT_HI constants.
  - ExcCode constants: NONE=0, AdEL=4.
  - FSM state encodings: ISSUE, HOLD, DRAIN.
- One natural sub-module: fetch_npc (combinational next-PC priority mux).

Test Plan:
- Reset release, imem_ready tied 1:
  - imem_addr=0x3000, 0x3004, 0x3008 on consecutive cycles.
  - valid_F=1 every cycle; instr_F=rdata.
- imem_ready low 3 cycles at PC 0x3004:
  - imem_addr held 0x3004.
  - valid_F=0 and instr_F=0 for 3 cycles, then rdata delivered and PC→0x3008.
- stall_D=1 two cycles while ready returns:
  - FSM enters HOLD; imem_req=0; instr_F stays the buffered word.
  - After release, PC→next; no duplicate request.
- Branch taken with the delay slot slow (ready after 2 cycles, branch leaves D meanwhile, target_D=0x3100):
  - Delay slot arrives with BD_F=1.
  - Next imem_addr=0x3100.
- Req while ISSUE waits on PC 0x3010:
  - Discarded response seen with valid_F=0.
  - Then imem_addr=0x4180, bd_pend=0.
- Jump to 0x2FFC and separately 0x3002:
  - No imem_req; valid_F=1, instr_F=0, ExcCode_F=4, PC_F=the bad PC.
- eret_D with EPC=0x3040, stall_D=0:
  - valid_F=0 that cycle; next imem_addr=0x3040.
